// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the I/D main-memory arbiter.
// Optional build macro used by the arbiter: MEM_ARB_RR_EN (round-robin tie break).

package mem_arb_pkg;

   // Default geometry: 28-bit line address, 128-bit cache line.
   localparam int ARB_ADDR_W = 28;
   localparam int ARB_DATA_W = 128;

   // Arbiter FSM encoding.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY    = 2'd1,
      RELEASE = 2'd2
   } arb_state_e;

   // Grant / last-served encoding.
   localparam logic GRANT_I = 1'b0;
   localparam logic GRANT_D = 1'b1;

   // A side is requesting when it asks for either a read or a write.
   function automatic logic side_req(input logic rd, input logic wr);
      return rd | wr;
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: cache <-> memory line-transfer bundle.
// The requester (a cache, or the arbiter toward memory) uses the master
// modport; the responder (the arbiter toward a cache, or memory) uses slave.

interface mem_arbiter_if
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = ARB_ADDR_W,
   parameter int DATA_W = ARB_DATA_W
) ();

   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;

   modport master (
      output mem_read,
      output mem_write,
      output mem_addr,
      output mem_wdata,
      input  mem_rdata,
      input  mem_ready
   );

   modport slave (
      input  mem_read,
      input  mem_write,
      input  mem_addr,
      input  mem_wdata,
      output mem_rdata,
      output mem_ready
   );

endinterface

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner selection for the memory arbiter.
// Build macro MEM_ARB_RR_EN: when defined, a tie goes to the side that was not
// served last; otherwise the D side always beats the I side.
// The result is only meaningful when at least one side is requesting.

module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic req_i,
   input  logic req_d,
   input  logic last_r,
   output logic win_d
);

`ifdef MEM_ARB_RR_EN
   // Round robin on a tie, otherwise the single requester wins.
   always_comb begin
      win_d = req_d ? GRANT_D : GRANT_I;
      if (req_i && req_d) begin
         win_d = ~last_r;
      end
   end
`else
   // Fixed priority: any D request wins; last_r and req_i do not affect the pick.
   logic [1:0] unused_pick_inputs;
   assign unused_pick_inputs = {req_i, last_r};

   assign win_d = req_d ? GRANT_D : GRANT_I;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single 128-bit main-memory port between the
// I-cache and the D-cache. One side is granted at a time and the grant is held
// until memory signals completion (or the granted side withdraws its request).
// A one-cycle RELEASE gap absorbs the caches' registered-ready lag so a request
// still high on the cycle after ready is not granted a second time.
// Build macro MEM_ARB_RR_EN selects round-robin tie breaking (see mem_arb_pick).

module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = ARB_ADDR_W,
   parameter int DATA_W = ARB_DATA_W
) (
   input  logic           clk,
   input  logic           proc_reset,
   mem_arbiter_if.slave   i_cache,
   mem_arbiter_if.slave   d_cache,
   mem_arbiter_if.master  memory,
   output logic           arb_busy,
   output logic           arb_grant_d
);

   arb_state_e        state_r;
   arb_state_e        state_nx;
   logic              grant_r;
   logic              grant_nx;
   logic              last_r;
   logic              last_nx;

   logic              req_i;
   logic              req_d;
   logic              win_d;

   logic              sel_read;
   logic              sel_write;
   logic              sel_req;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   logic              out_read;
   logic              out_write;
   logic [ADDR_W-1:0] out_addr;
   logic [DATA_W-1:0] out_wdata;

   logic              in_busy;

   assign req_i   = side_req(i_cache.mem_read, i_cache.mem_write);
   assign req_d   = side_req(d_cache.mem_read, d_cache.mem_write);
   assign in_busy = (state_r == BUSY);

   mem_arb_pick u_pick (
      .req_i  (req_i),
      .req_d  (req_d),
      .last_r (last_r),
      .win_d  (win_d)
   );

   // Request fields of the currently granted side.
   always_comb begin
      if (grant_r == GRANT_D) begin
         sel_read  = d_cache.mem_read;
         sel_write = d_cache.mem_write;
         sel_addr  = d_cache.mem_addr;
         sel_wdata = d_cache.mem_wdata;
      end else begin
         sel_read  = i_cache.mem_read;
         sel_write = i_cache.mem_write;
         sel_addr  = i_cache.mem_addr;
         sel_wdata = i_cache.mem_wdata;
      end
   end

   assign sel_req = sel_read | sel_write;

   // FSM and grant/last-served registers; reset leaves I favoured for the first tie.
   always_ff @(posedge clk or posedge proc_reset) begin
      if (proc_reset) begin
         state_r <= IDLE;
         grant_r <= GRANT_I;
         last_r  <= GRANT_D;
      end else begin
         state_r <= state_nx;
         grant_r <= grant_nx;
         last_r  <= last_nx;
      end
   end

   // Next-state: grant in IDLE, hold in BUSY until ready or abort, one RELEASE cycle.
   always_comb begin
      state_nx = state_r;
      grant_nx = grant_r;
      last_nx  = last_r;
      case (state_r)
         IDLE: begin
            if (req_i || req_d) begin
               grant_nx = win_d;
               state_nx = BUSY;
            end
         end
         BUSY: begin
            if (memory.mem_ready) begin
               last_nx  = grant_r;
               state_nx = RELEASE;
            end else if (!sel_req) begin
               state_nx = IDLE;
            end
         end
         RELEASE: begin
            state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // Memory request drive: granted side passes through only while BUSY and still requesting.
   always_comb begin
      out_read  = 1'b0;
      out_write = 1'b0;
      out_addr  = '0;
      out_wdata = '0;
      if (in_busy && sel_req) begin
         // A combined read+write request is a write.
         out_write = sel_write;
         out_read  = sel_read & ~sel_write;
         out_addr  = sel_addr;
         out_wdata = sel_wdata;
      end
   end

   assign memory.mem_read  = out_read;
   assign memory.mem_write = out_write;
   assign memory.mem_addr  = out_addr;
   assign memory.mem_wdata = out_wdata;

   // Completion is routed only to the granted side and only while BUSY.
   assign i_cache.mem_ready = memory.mem_ready & in_busy & (grant_r == GRANT_I);
   assign d_cache.mem_ready = memory.mem_ready & in_busy & (grant_r == GRANT_D);

   // Read data is broadcast; ready alone qualifies it.
   assign i_cache.mem_rdata = memory.mem_rdata;
   assign d_cache.mem_rdata = memory.mem_rdata;

   assign arb_busy    = in_busy;
   assign arb_grant_d = grant_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios with literal expectations followed by
// randomized traffic, all checked every cycle against a transaction-level
// model of the arbiter (who owns the port, whether a release gap is pending).

module tb_mem_arbiter;
   import mem_arb_pkg::*;

   logic clk = 1'b0;
   logic proc_reset;
   logic arb_busy;
   logic arb_grant_d;

   int tests = 0;
   int fails = 0;

   mem_arbiter_if #(.ADDR_W(28), .DATA_W(128)) i_if ();
   mem_arbiter_if #(.ADDR_W(28), .DATA_W(128)) d_if ();
   mem_arbiter_if #(.ADDR_W(28), .DATA_W(128)) mem_if ();

   mem_arbiter #(.ADDR_W(28), .DATA_W(128)) dut (
      .clk         (clk),
      .proc_reset  (proc_reset),
      .i_cache     (i_if),
      .d_cache     (d_if),
      .memory      (mem_if),
      .arb_busy    (arb_busy),
      .arb_grant_d (arb_grant_d)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Drive point: 1 ns after the rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      i_if.mem_read    = 1'b0;
      i_if.mem_write   = 1'b0;
      i_if.mem_addr    = '0;
      i_if.mem_wdata   = '0;
      d_if.mem_read    = 1'b0;
      d_if.mem_write   = 1'b0;
      d_if.mem_addr    = '0;
      d_if.mem_wdata   = '0;
      mem_if.mem_rdata = '0;
      mem_if.mem_ready = 1'b0;
   endtask

   task automatic pulse_reset();
      clear_inputs();
      proc_reset = 1'b1;
      cyc();
      proc_reset = 1'b0;
   endtask

   // Called at the drive point of the first BUSY cycle of a grant: two BUSY
   // cycles, memory ready on the second, then checks the RELEASE cycle.
   task automatic serve(input string tg, input bit sd, input logic [27:0] a,
                        input bit wr, input logic [127:0] wd);
      for (int k = 0; k < 2; k++) begin
         if (k == 1) mem_if.mem_ready = 1'b1;
         @(negedge clk);
         chk({tg, "_busy"},  arb_busy, 1'b1);
         chk({tg, "_grant"}, arb_grant_d, sd);
         chk({tg, "_addr"},  mem_if.mem_addr, a);
         chk({tg, "_write"}, mem_if.mem_write, wr);
         chk({tg, "_read"},  mem_if.mem_read, !wr);
         if (wr) chk({tg, "_wdata"}, mem_if.mem_wdata, wd);
         chk({tg, "_irdy"}, i_if.mem_ready, (k == 1) && !sd);
         chk({tg, "_drdy"}, d_if.mem_ready, (k == 1) && sd);
         cyc();
      end
      mem_if.mem_ready = 1'b0;
      @(negedge clk);
      chk({tg, "_rel_busy"}, arb_busy, 1'b0);
      chk({tg, "_rel_req"},  {mem_if.mem_read, mem_if.mem_write}, 2'b00);
      chk({tg, "_rel_rdy"},  {i_if.mem_ready, d_if.mem_ready}, 2'b00);
   endtask

   // Transaction-level reference: owner 0 = none, 1 = I, 2 = D; gap marks the
   // post-completion cycle in which nothing may be granted.
   int m_srv = 0;
   int m_gap = 0;
   bit m_last = 1'b1;

   initial begin : model_chk
      logic ri, rq, sd, s_rd, s_wr, s_rq;
      logic [27:0]  s_a, e_a;
      logic [127:0] s_wd, e_wd;
      logic e_rd, e_wr, e_ir, e_dr, e_busy;
      int n_srv, n_gap;
      bit n_last;
      forever begin
         @(negedge clk);
         if (proc_reset) begin
            chk("rst_ctl", {mem_if.mem_read, mem_if.mem_write, i_if.mem_ready,
                            d_if.mem_ready, arb_busy, arb_grant_d}, 6'd0);
            chk("rst_addr",  mem_if.mem_addr, 28'd0);
            chk("rst_wdata", mem_if.mem_wdata, 128'd0);
            m_srv  = 0;
            m_gap  = 0;
            m_last = 1'b1;
         end else begin
            ri = i_if.mem_read | i_if.mem_write;
            rq = d_if.mem_read | d_if.mem_write;
            e_rd = 1'b0; e_wr = 1'b0; e_ir = 1'b0; e_dr = 1'b0; e_busy = 1'b0;
            e_a = '0; e_wd = '0;
            n_srv = m_srv; n_gap = 0; n_last = m_last;
            if (m_srv != 0) begin
               sd   = (m_srv == 2);
               s_rd = sd ? d_if.mem_read  : i_if.mem_read;
               s_wr = sd ? d_if.mem_write : i_if.mem_write;
               s_a  = sd ? d_if.mem_addr  : i_if.mem_addr;
               s_wd = sd ? d_if.mem_wdata : i_if.mem_wdata;
               s_rq = s_rd | s_wr;
               e_busy = 1'b1;
               if (s_rq) begin
                  e_wr = s_wr;
                  e_rd = s_rd & !s_wr;
                  e_a  = s_a;
                  e_wd = s_wd;
               end
               if (mem_if.mem_ready) begin
                  if (sd) e_dr = 1'b1; else e_ir = 1'b1;
                  n_srv  = 0;
                  n_gap  = 1;
                  n_last = sd;
               end else if (!s_rq) begin
                  n_srv = 0;
               end
               chk("m_grant", arb_grant_d, sd);
            end else if (m_gap == 0 && (ri || rq)) begin
`ifdef MEM_ARB_RR_EN
               if (ri && rq) n_srv = m_last ? 1 : 2;
               else          n_srv = rq ? 2 : 1;
`else
               n_srv = rq ? 2 : 1;
`endif
            end
            chk("m_ctl", {mem_if.mem_read, mem_if.mem_write, i_if.mem_ready,
                          d_if.mem_ready, arb_busy},
                         {e_rd, e_wr, e_ir, e_dr, e_busy});
            chk("m_addr",    mem_if.mem_addr, e_a);
            chk("m_wdata",   mem_if.mem_wdata, e_wd);
            chk("m_rdata_i", i_if.mem_rdata, mem_if.mem_rdata);
            chk("m_rdata_d", d_if.mem_rdata, mem_if.mem_rdata);
            m_srv  = n_srv;
            m_gap  = n_gap;
            m_last = n_last;
         end
      end
   end

   initial begin : stim
      bit first_d;
      logic [127:0] wd;
      logic ird, iwr, drd, dwr;
      logic [27:0] ia, da;
      int k;

      clear_inputs();
      proc_reset = 1'b1;
      cyc();
      cyc();
      proc_reset = 1'b0;
      cyc();

      // I-only read of 0x10, memory ready on cycle 6.
      i_if.mem_read = 1'b1;
      i_if.mem_addr = 28'h0000010;
      @(negedge clk);
      chk("t1_c0_read", mem_if.mem_read, 1'b0);
      for (int c = 1; c <= 6; c++) begin
         cyc();
         if (c == 6) mem_if.mem_ready = 1'b1;
         @(negedge clk);
         chk("t1_read", mem_if.mem_read, 1'b1);
         chk("t1_addr", mem_if.mem_addr, 28'h0000010);
         chk("t1_irdy", i_if.mem_ready, c == 6);
         chk("t1_drdy", d_if.mem_ready, 1'b0);
      end
      cyc();
      mem_if.mem_ready = 1'b0;
      @(negedge clk);
      chk("t1_rel_busy", arb_busy, 1'b0);
      chk("t1_rel_read", mem_if.mem_read, 1'b0);
      chk("t1_rel_irdy", i_if.mem_ready, 1'b0);
      cyc();
      i_if.mem_read = 1'b0;
      @(negedge clk);
      chk("t1_idle_busy", arb_busy, 1'b0);
      cyc();

      // Both sides read at cycle 0.
`ifdef MEM_ARB_RR_EN
      first_d = 1'b0;
`else
      first_d = 1'b1;
`endif
      pulse_reset();
      i_if.mem_read = 1'b1; i_if.mem_addr = 28'h10;
      d_if.mem_read = 1'b1; d_if.mem_addr = 28'h20;
      cyc();
      serve("t2a", first_d, first_d ? 28'h20 : 28'h10, 1'b0, '0);
      cyc();
      if (first_d) d_if.mem_read = 1'b0; else i_if.mem_read = 1'b0;
      cyc();
      serve("t2b", !first_d, first_d ? 28'h10 : 28'h20, 1'b0, '0);
      cyc();
      clear_inputs();
      cyc();

      // D writeback then allocate, I read pending.
      pulse_reset();
      d_if.mem_write = 1'b1; d_if.mem_addr = 28'h30; d_if.mem_wdata = {16{8'hA5}};
      cyc();
      i_if.mem_read = 1'b1; i_if.mem_addr = 28'h50;
      serve("t3wb", 1'b1, 28'h30, 1'b1, {16{8'hA5}});
      cyc();
      d_if.mem_write = 1'b0; d_if.mem_read = 1'b1; d_if.mem_addr = 28'h40;
      cyc();
`ifdef MEM_ARB_RR_EN
      serve("t3i", 1'b0, 28'h50, 1'b0, '0);
      cyc();
      i_if.mem_read = 1'b0;
      cyc();
      serve("t3d", 1'b1, 28'h40, 1'b0, '0);
      cyc();
      d_if.mem_read = 1'b0;
`else
      serve("t3d", 1'b1, 28'h40, 1'b0, '0);
      cyc();
      d_if.mem_read = 1'b0;
      cyc();
      serve("t3i", 1'b0, 28'h50, 1'b0, '0);
      cyc();
      i_if.mem_read = 1'b0;
`endif
      cyc();

      // Asynchronous reset in the middle of a D write.
      wd = {$urandom, $urandom, $urandom, $urandom};
      d_if.mem_write = 1'b1; d_if.mem_addr = 28'h60; d_if.mem_wdata = wd;
      cyc();
      cyc();
      @(negedge clk);
      chk("t4_pre_write", mem_if.mem_write, 1'b1);
      cyc();
      mem_if.mem_ready = 1'b1;
      proc_reset = 1'b1;
      #1;
      chk("t4_write", mem_if.mem_write, 1'b0);
      chk("t4_busy",  arb_busy, 1'b0);
      chk("t4_drdy",  d_if.mem_ready, 1'b0);
      chk("t4_grant", arb_grant_d, 1'b0);
      d_if.mem_write = 1'b0;
      mem_if.mem_ready = 1'b0;
      cyc();
      proc_reset = 1'b0;
      @(negedge clk);
      chk("t4_post_busy", arb_busy, 1'b0);
      chk("t4_post_rdy", {i_if.mem_ready, d_if.mem_ready}, 2'b00);
      cyc();

      // Granted D withdraws its read mid-BUSY while I waits.
      d_if.mem_read = 1'b1; d_if.mem_addr = 28'h70;
      cyc();
      i_if.mem_read = 1'b1; i_if.mem_addr = 28'h80;
      @(negedge clk);
      chk("t5_grant", arb_grant_d, 1'b1);
      chk("t5_addr",  mem_if.mem_addr, 28'h70);
      cyc();
      d_if.mem_read = 1'b0;
      @(negedge clk);
      chk("t5_abort_read", mem_if.mem_read, 1'b0);
      chk("t5_abort_drdy", d_if.mem_ready, 1'b0);
      cyc();
      @(negedge clk);
      chk("t5_idle_busy", arb_busy, 1'b0);
      cyc();
      serve("t5i", 1'b0, 28'h80, 1'b0, '0);
      cyc();
      i_if.mem_read = 1'b0;
      cyc();

      // Combined read+write from D is a write.
      wd = {$urandom, $urandom, $urandom, $urandom};
      d_if.mem_read = 1'b1; d_if.mem_write = 1'b1; d_if.mem_addr = 28'h90;
      d_if.mem_wdata = wd;
      cyc();
      serve("t6", 1'b1, 28'h90, 1'b1, wd);
      cyc();
      clear_inputs();
      cyc();

      // Randomized traffic, checked by the model every cycle.
      ird = 0; iwr = 0; drd = 0; dwr = 0; ia = '0; da = '0;
      for (int n = 0; n < 3000; n++) begin
         cyc();
         if (!(ird || iwr)) begin
            if ($urandom_range(0, 3) == 0) begin
               k = $urandom_range(0, 5);
               ird = (k < 4) || (k == 5);
               iwr = (k >= 4);
               ia  = 28'($urandom);
            end
         end else if ($urandom_range(0, 11) == 0) begin
            ird = 0; iwr = 0;
         end else if ($urandom_range(0, 7) == 0) begin
            ia = 28'($urandom);
         end
         if (!(drd || dwr)) begin
            if ($urandom_range(0, 3) == 0) begin
               k = $urandom_range(0, 5);
               drd = (k < 4) || (k == 5);
               dwr = (k >= 4);
               da  = 28'($urandom);
            end
         end else if ($urandom_range(0, 11) == 0) begin
            drd = 0; dwr = 0;
         end else if ($urandom_range(0, 7) == 0) begin
            da = 28'($urandom);
         end
         i_if.mem_read    = ird;
         i_if.mem_write   = iwr;
         i_if.mem_addr    = ia;
         i_if.mem_wdata   = {$urandom, $urandom, $urandom, $urandom};
         d_if.mem_read    = drd;
         d_if.mem_write   = dwr;
         d_if.mem_addr    = da;
         d_if.mem_wdata   = {$urandom, $urandom, $urandom, $urandom};
         mem_if.mem_rdata = {$urandom, $urandom, $urandom, $urandom};
         mem_if.mem_ready = ($urandom_range(0, 3) == 0);
      end
      cyc();
      clear_inputs();
      cyc();
      cyc();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single 128-bit main-memory port between the instruction cache (I side) and the data cache (D side).
- Each side presents the same read/write/addr/wdata request and rdata/ready response used by the cache memory interface. The arbiter grants one side at a time and holds the grant until the transaction completes.
- Sits between both caches and the memory model at CPU top level.

Parameters:
- ADDR_W, 28, block address width (word address >> 2).
- DATA_W, 128, cache line width.

Ports:
- clk  in  1  single clock, rising edge.
- proc_reset  in  1  asynchronous, active-high reset.
- i_mem_read  in  1  I-cache read request.
- i_mem_write  in  1  I-cache write request (normally 0).
- i_mem_addr  in  ADDR_W  I-cache line address.
- i_mem_wdata  in  DATA_W  I-cache writeback data.
- i_mem_rdata  out  DATA_W  line data to I-cache.
- i_mem_ready  out  1  completion pulse to I-cache.
- d_mem_read, d_mem_write, d_mem_addr, d_mem_wdata, d_mem_rdata, d_mem_ready: same as the I side, for the D-cache.
- mem_read  out  1  read request to memory.
- mem_write  out  1  write request to memory.
- mem_addr  out  ADDR_W  address to memory.
- mem_wdata  out  DATA_W  write data to memory.
- mem_rdata  in  DATA_W  read data from memory.
- mem_ready  in  1  memory completion pulse.
- arb_busy  out  1  high in BUSY state (debug/perf).
- arb_grant_d  out  1  registered grant: 1 = D side, 0 = I side.

Behaviour:
- Side request: req_x = x_mem_read | x_mem_write. If both are high, the request is treated as a write: mem_read is forced to 0.
- States: IDLE, BUSY, RELEASE (2-bit). Registered: state_r, grant_r, last_r (last side served).
- IDLE:
  - All memory outputs are 0 (addr/wdata 0).
  - If any req is high, pick a winner, grant_r <= winner, go to BUSY.
  - Otherwise stay in IDLE.
- Winner selection, fixed priority: D beats I.
- BUSY:
  - mem_read, mem_write, mem_addr and mem_wdata are a combinational mux of the granted side. The cache wdata register is valid by this cycle, so no capture is needed.
  - x_mem_ready = mem_ready & (grant == x), same cycle. The non-granted side's ready is always 0.
  - On mem_ready: last_r <= grant_r, go to RELEASE.
  - If the granted side drops req without mem_ready (abort): go to IDLE, memory request deasserts that cycle.
- RELEASE:
  - Exactly one cycle; memory request outputs are 0, both readies are 0; go to IDLE.
  - Covers the cache's one-cycle registered-ready lag: its request is still high on the ready cycle and is not re-granted.
- rdata: mem_rdata is broadcast unregistered to both sides; only ready qualifies it.
- Latency:
  - Request seen in IDLE at cycle N puts the request on memory at N+1.
  - mem_ready at cycle M allows the next grant decision at M+2 and memory drive at M+3.
- A simultaneous new request from the other side while BUSY waits; no preemption.
- mem_ready outside BUSY is ignored.
- Reset (asynchronous, any state, including mid-BUSY): state_r=IDLE, grant_r=0, last_r=1 (D), so I wins the first round-robin tie. All memory outputs, both readies, arb_busy and arb_grant_d go to 0 immediately.

Optional Feature:
- MEM_ARB_RR_EN defined: when both sides request in IDLE, winner = side opposite last_r (round robin). A single requester always wins.
- Undefined: fixed D-over-I priority; last_r is still maintained but unused.

Decomposition:
- Package mem_arb_pkg holds:
  - state encodings IDLE=2'd0, BUSY=2'd1, RELEASE=2'd2;
  - GRANT_I=1'b0, GRANT_D=1'b1;
  - ADDR_W/DATA_W defaults.
- One sub-module, mem_arb_pick: combinational winner from req_i, req_d, last_r; contains the MEM_ARB_RR_EN branch.
- Top holds the FSM and muxes.

Test Plan:
- I-only read addr 0x0000010 at cycle 0, memory ready at cycle 6:
  - mem_read=1, mem_addr=0x0000010 from cycle 1 to 6;
  - i_mem_ready=1 at cycle 6 only, d_mem_ready=0 throughout;
  - RELEASE at 7, IDLE at 8.
- I read 0x10 and D read 0x20 both at cycle 0, fixed priority:
  - D is served first;
  - I is granted after D's RELEASE, and mem_addr switches to 0x10.
  - With MEM_ARB_RR_EN, after reset I is served first, then D.
- D writeback (write 0x30, wdata 0xA5..A5) followed by allocate (read 0x40), with I pending, MEM_ARB_RR_EN on:
  - order is D-write, I-read, D-read;
  - mem_wdata=0xA5..A5 throughout the write grant.
- proc_reset pulsed while BUSY with D write:
  - mem_write, arb_busy and d_mem_ready are 0 immediately;
  - after release, the FSM is in IDLE with no spurious ready.
- Granted D drops d_mem_read mid-BUSY:
  - mem_read=0 that cycle, FSM returns to IDLE;
  - a pending I request is granted next cycle.
- D asserts read and write together:
  - mem_write=1, mem_read=0.
